// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel: packed channel inputs, control, and the registered lane outputs.
interface mux_scan_sel_if #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned DWELL_W  = 8
);
    logic [CHANNELS*WIDTH-1:0] in;
    logic                      en;
    logic                      mode;
    logic [SEL_W-1:0]          select;
    logic [DWELL_W-1:0]        dwell;
    logic [WIDTH-1:0]          out;
    logic [SEL_W-1:0]          cur_sel;
    logic                      out_valid;
    logic                      wrap;

    modport master (
        output in, en, mode, select, dwell,
        input  out, cur_sel, out_valid, wrap
    );

    modport slave (
        input  in, en, mode, select, dwell,
        output out, cur_sel, out_valid, wrap
    );
endinterface

// File: rtl/mux_scan_sel.sv
// Registered N-channel lane selector with manual select and auto-scan (programmable dwell).
module mux_scan_sel #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned DWELL_W  = 8
) (
    input logic           clk,
    input logic           rst,
    mux_scan_sel_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   lane_d;
    logic               sel_ok;
    logic               cur_ok;
    logic               cur_last;

    assign cur_ok   = 32'(cur_sel_q) < CHANNELS;
    assign cur_last = 32'(cur_sel_q) == CHANNELS - 1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every enabled edge follows mode; en low freezes the state
    always_comb begin
        state_d = state_q;
        if (bus.en) begin
            state_d = bus.mode ? StScan : StManual;
        end
    end

    // Datapath next values, chosen by the transition being taken
    always_comb begin
        cur_sel_d = cur_sel_q;
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        if (bus.en) begin
            if (state_d == StManual) begin
                cur_sel_d = bus.select;
                cnt_d     = '0;
            end else if (state_q != StScan) begin
                // Entering scan: resume from the manual channel if it names a real lane
                cur_sel_d = cur_ok ? cur_sel_q : '0;
                cnt_d     = '0;
            end else if (cnt_q == bus.dwell) begin
                cnt_d = '0;
                if (cur_last) begin
                    cur_sel_d = '0;
                    wrap_d    = 1'b1;
                end else begin
                    cur_sel_d = cur_sel_q + SEL_W'(1);
                end
            end else begin
                // Wraps modulo 2**DWELL_W if dwell was lowered below the running count
                cnt_d = cnt_q + DWELL_W'(1);
            end
        end
    end

    always_comb begin
        lane_d = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (32'(cur_sel_d) == k) begin
                lane_d = bus.in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_ok = 32'(cur_sel_d) < CHANNELS;

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (bus.en) begin
            out_d       = sel_ok ? lane_d : '0;
            out_valid_d = sel_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cur_sel_q   <= cur_sel_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.cur_sel   = cur_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: three configurations sharing one clock and reset.
module tb_mux_scan_sel;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mux_scan_sel_if #(.WIDTH(1), .CHANNELS(16), .SEL_W(4), .DWELL_W(8)) if_a ();
    mux_scan_sel_if #(.WIDTH(8), .CHANNELS(4),  .SEL_W(2), .DWELL_W(8)) if_b ();
    mux_scan_sel_if #(.WIDTH(8), .CHANNELS(12), .SEL_W(4), .DWELL_W(8)) if_c ();

    mux_scan_sel #(.WIDTH(1), .CHANNELS(16), .SEL_W(4), .DWELL_W(8)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );
    mux_scan_sel #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL_W(8)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );
    mux_scan_sel #(.WIDTH(8), .CHANNELS(12), .SEL_W(4), .DWELL_W(8)) u_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c.slave)
    );

    typedef struct {
        logic [3:0] sel;
        logic [7:0] out;
        logic       valid;
    } vec_t;

    vec_t vec_a[8];
    vec_t vec_c[7];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if_a.in = 16'h3f0a; if_a.en = 1'b0; if_a.mode = 1'b0; if_a.select = '0; if_a.dwell = '0;
        if_b.in = 32'hDD_CC_BB_AA; if_b.en = 1'b0; if_b.mode = 1'b1; if_b.select = '0;
        if_b.dwell = 8'd2;
        if_c.in = '0; if_c.en = 1'b0; if_c.mode = 1'b0; if_c.select = '0; if_c.dwell = '0;
        for (int k = 0; k < 12; k++) if_c.in[k*8 +: 8] = 8'(8'h50 + k);

        vec_a[0] = '{4'd0,  8'h0, 1'b1};
        vec_a[1] = '{4'd1,  8'h1, 1'b1};
        vec_a[2] = '{4'd4,  8'h0, 1'b1};
        vec_a[3] = '{4'd6,  8'h0, 1'b1};
        vec_a[4] = '{4'd12, 8'h1, 1'b1};
        vec_a[5] = '{4'd9,  8'h1, 1'b1};
        vec_a[6] = '{4'd15, 8'h0, 1'b1};
        vec_a[7] = '{4'd3,  8'h1, 1'b1};

        vec_c[0] = '{4'hE, 8'h00, 1'b0};
        vec_c[1] = '{4'h3, 8'h53, 1'b1};
        vec_c[2] = '{4'hB, 8'h5B, 1'b1};
        vec_c[3] = '{4'hC, 8'h00, 1'b0};
        vec_c[4] = '{4'h0, 8'h50, 1'b1};
        vec_c[5] = '{4'hF, 8'h00, 1'b0};
        vec_c[6] = '{4'h3, 8'h53, 1'b1};

        // Reset values, before any clock edge
        #2;
        check("rst_a_out", 32'(if_a.out), 0);
        check("rst_a_valid", 32'(if_a.out_valid), 0);
        check("rst_b_cur", 32'(if_b.cur_sel), 0);
        check("rst_c_wrap", 32'(if_c.wrap), 0);
        #3 rst = 1'b0;

        // Manual select, 1-bit lanes
        if_a.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if_a.select = vec_a[i].sel;
            tick();
            check("man_a_out", 32'(if_a.out), 32'(vec_a[i].out[0]));
            check("man_a_valid", 32'(if_a.out_valid), 32'(vec_a[i].valid));
            check("man_a_cur", 32'(if_a.cur_sel), 32'(vec_a[i].sel));
        end
        if_a.en = 1'b0;

        // Auto-scan, 4 x 8-bit lanes, dwell 2
        if_b.en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            check("scan_b_cur", 32'(if_b.cur_sel), 32'((k / 3) % 4));
            check("scan_b_out", 32'(if_b.out), 32'(8'hAA) + 32'(8'h11) * 32'((k / 3) % 4));
            check("scan_b_wrap", 32'(if_b.wrap), (k == 12) ? 1 : 0);
            check("scan_b_valid", 32'(if_b.out_valid), 1);
        end
        if_b.en = 1'b0;

        // Manual with out-of-range selects on 12 channels
        if_c.en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if_c.select = vec_c[i].sel;
            tick();
            check("man_c_out", 32'(if_c.out), 32'(vec_c[i].out));
            check("man_c_valid", 32'(if_c.out_valid), 32'(vec_c[i].valid));
            check("man_c_cur", 32'(if_c.cur_sel), 32'(vec_c[i].sel));
        end

        // Scan dwell 0 from channel 3, freeze at channel 5
        if_c.mode = 1'b1;
        if_c.dwell = 8'd0;
        tick();
        check("m2s_start_cur", 32'(if_c.cur_sel), 3);
        tick();
        tick();
        check("d0_cur5", 32'(if_c.cur_sel), 5);
        if_c.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_cur", 32'(if_c.cur_sel), 5);
            check("frz_out", 32'(if_c.out), 32'h55);
            check("frz_valid", 32'(if_c.out_valid), 0);
            check("frz_wrap", 32'(if_c.wrap), 0);
        end
        if_c.en = 1'b1;
        for (int k = 6; k < 14; k++) begin
            tick();
            check("d0_cur", 32'(if_c.cur_sel), 32'(k % 12));
            check("d0_out", 32'(if_c.out), 32'(8'h50) + 32'(k % 12));
            check("d0_wrap", 32'(if_c.wrap), (k == 12) ? 1 : 0);
        end

        // Manual 7, then scan dwell 1, then back to manual 2
        if_c.mode = 1'b0;
        if_c.select = 4'd7;
        tick();
        check("m7_out", 32'(if_c.out), 32'h57);
        if_c.mode = 1'b1;
        if_c.dwell = 8'd1;
        tick();
        check("h7a_cur", 32'(if_c.cur_sel), 7);
        tick();
        check("h7b_cur", 32'(if_c.cur_sel), 7);
        tick();
        check("h8a_cur", 32'(if_c.cur_sel), 8);
        check("h8a_out", 32'(if_c.out), 32'h58);
        if_c.mode = 1'b0;
        if_c.select = 4'd2;
        tick();
        check("back_m2_out", 32'(if_c.out), 32'h52);
        check("back_m2_cur", 32'(if_c.cur_sel), 2);
        check("back_m2_wrap", 32'(if_c.wrap), 0);

        // Mode change while disabled must not take effect
        if_c.en = 1'b0;
        if_c.mode = 1'b1;
        tick();
        check("dis_mode_valid", 32'(if_c.out_valid), 0);
        if_c.en = 1'b1;
        if_c.mode = 1'b0;
        if_c.select = 4'd4;
        tick();
        check("dis_mode_cur", 32'(if_c.cur_sel), 4);
        check("dis_mode_out", 32'(if_c.out), 32'h54);

        // Async reset mid-scan at channel 9
        if_c.mode = 1'b1;
        if_c.dwell = 8'd0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_cur", 32'(if_c.cur_sel), 9);
        #2 rst = 1'b1;
        #1;
        check("arst_out", 32'(if_c.out), 0);
        check("arst_cur", 32'(if_c.cur_sel), 0);
        check("arst_valid", 32'(if_c.out_valid), 0);
        #1 rst = 1'b0;
        tick();
        check("post_rst_cur", 32'(if_c.cur_sel), 0);
        check("post_rst_out", 32'(if_c.out), 32'h50);
        check("post_rst_valid", 32'(if_c.out_valid), 1);
        tick();
        check("post_rst_cur1", 32'(if_c.cur_sel), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
